imem_arbiter: RTL and testbench

//  Shares one single-port, word-organised instruction memory between two requesters:
//  the CPU fetch port (read-only) and the program loader/debug port (read/write).

---
 rtl/imem_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_imem_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_arbiter.sv
// -----------------------------------------------------------------------------
// imem_arbiter
//
// Shares one single-port, word-organised instruction memory between the CPU
// fetch port (read-only) and the program loader/debug port (read/write).
// The loader normally has priority. A starvation counter makes sure fetch
// still wins after STARVE_MAX consecutive lost arbitrations. The loader can
// also take the memory exclusively with loadLock, which blocks fetch entirely.
//
// Ports
//   clk, rst_n              rising-edge clock, asynchronous active-low reset
//   fetchReq/fetchAddr      fetch read request, held until fetchGnt
//   fetchGnt                fetch accepted this cycle (combinational)
//   fetchValid/Instr/Err    fetch response, one cycle after the grant
//   loadReq/We/Addr/Data    loader request, held until loadGnt
//   loadLock                request exclusive loader ownership
//   loadGnt                 loader accepted this cycle (combinational)
//   loadValid/Rdata/Err     loader response, one cycle after the grant
//   locked                  arbiter is in the LOCK state
//   memEn/We/Addr/Wdata     memory strobe, write enable, word index, write data
//   memRdata                memory read data, valid the cycle after a read strobe
// -----------------------------------------------------------------------------
module imem_arbiter #(
    parameter int DEPTH      = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     fetchReq,
    input  logic [31:0]              fetchAddr,
    output logic                     fetchGnt,
    output logic                     fetchValid,
    output logic [31:0]              fetchInstr,
    output logic                     fetchErr,
    input  logic                     loadReq,
    input  logic                     loadWe,
    input  logic [31:0]              loadAddr,
    input  logic [31:0]              loadData,
    input  logic                     loadLock,
    output logic                     loadGnt,
    output logic                     loadValid,
    output logic [31:0]              loadRdata,
    output logic                     loadErr,
    output logic                     locked,
    output logic                     memEn,
    output logic                     memWe,
    output logic [$clog2(DEPTH)-1:0] memAddr,
    output logic [31:0]              memWdata,
    input  logic [31:0]              memRdata
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIMIT = SW'(STARVE_MAX);

    typedef enum logic {
        RUN  = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t        state_reg, state_next;
    logic [SW-1:0] starve_reg, starve_next;

    // Address legality for both requesters: index 0 = fetch, 1 = loader.
    logic [31:0] req_addr [2];
    logic [1:0]  addr_ok;

    assign req_addr[0] = fetchAddr;
    assign req_addr[1] = loadAddr;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_addr_chk
            assign addr_ok[gi] = (req_addr[gi][1:0] == 2'b00) &&
                                 (req_addr[gi][31:2] < 30'(DEPTH));
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Arbitration, state/starvation update and memory strobes
    // -------------------------------------------------------------------------
    always_comb begin
        state_next  = state_reg;
        starve_next = starve_reg;
        fetchGnt    = 1'b0;
        loadGnt     = 1'b0;
        memEn       = 1'b0;
        memWe       = 1'b0;
        memAddr     = '0;
        memWdata    = '0;

        case (state_reg)
            RUN: begin
                // Loader wins unless fetch has already lost STARVE_MAX times.
                // loadLock is not looked at here, so a fetch win in the cycle
                // the lock rises is still honoured.
                if (fetchReq && (!loadReq || (starve_reg == STARVE_LIMIT))) begin
                    fetchGnt = 1'b1;
                end else if (loadReq) begin
                    loadGnt = 1'b1;
                end

                if (!fetchReq || fetchGnt) begin
                    starve_next = '0;
                end else if (starve_reg != STARVE_LIMIT) begin
                    starve_next = starve_reg + 1'b1;
                end

                if (loadLock) begin
                    state_next = LOCK;
                end
            end
            LOCK: begin
                loadGnt     = loadReq;
                starve_next = '0;
                if (!loadLock) begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next  = RUN;
                starve_next = '0;
            end
        endcase

        // Illegal addresses are granted but never reach the memory.
        if (fetchGnt && addr_ok[0]) begin
            memEn   = 1'b1;
            memAddr = fetchAddr[AW+1:2];
        end else if (loadGnt && addr_ok[1]) begin
            memEn    = 1'b1;
            memWe    = loadWe;
            memAddr  = loadAddr[AW+1:2];
            memWdata = loadWe ? loadData : 32'h0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= RUN;
            starve_reg <= '0;
        end else begin
            state_reg  <= state_next;
            starve_reg <= starve_next;
        end
    end

    assign locked = (state_reg == LOCK);

    // -------------------------------------------------------------------------
    // Responses
    // Valid/Err are captured at the grant edge. The read data itself only
    // exists on memRdata in the response cycle, so it is steered through while
    // Valid is high and captured into a hold register for the idle cycles.
    // The *_mem_reg flag says whether the response carries memory data
    // (legal read) or must read as zero (error or write acknowledge).
    // -------------------------------------------------------------------------
    logic        fetch_valid_reg, fetch_err_reg, fetch_mem_reg;
    logic        load_valid_reg,  load_err_reg,  load_mem_reg;
    logic [31:0] fetch_hold_reg,  load_hold_reg;
    logic [31:0] fetch_data, load_data;

    assign fetch_data = fetch_mem_reg ? memRdata : 32'h0;
    assign load_data  = load_mem_reg  ? memRdata : 32'h0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_valid_reg <= 1'b0;
            fetch_err_reg   <= 1'b0;
            fetch_mem_reg   <= 1'b0;
            fetch_hold_reg  <= '0;
            load_valid_reg  <= 1'b0;
            load_err_reg    <= 1'b0;
            load_mem_reg    <= 1'b0;
            load_hold_reg   <= '0;
        end else begin
            fetch_valid_reg <= fetchGnt;
            load_valid_reg  <= loadGnt;
            if (fetchGnt) begin
                fetch_err_reg <= !addr_ok[0];
                fetch_mem_reg <= addr_ok[0];
            end
            if (loadGnt) begin
                load_err_reg <= !addr_ok[1];
                load_mem_reg <= addr_ok[1] && !loadWe;
            end
            if (fetch_valid_reg) begin
                fetch_hold_reg <= fetch_data;
            end
            if (load_valid_reg) begin
                load_hold_reg <= load_data;
            end
        end
    end

    assign fetchValid = fetch_valid_reg;
    assign fetchErr   = fetch_err_reg;
    assign fetchInstr = fetch_valid_reg ? fetch_data : fetch_hold_reg;
    assign loadValid  = load_valid_reg;
    assign loadErr    = load_err_reg;
    assign loadRdata  = load_valid_reg ? load_data : load_hold_reg;

endmodule

// File: tb/tb_imem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_imem_arbiter
//
// Directed bench for imem_arbiter (DEPTH=32, STARVE_MAX=4). A small word
// memory with a registered read port sits on the mem* interface; it is
// preloaded with 0xA500_0000 + index. Inputs change on the falling edge,
// combinational grants are checked just after that, registered responses
// one time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_imem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        fetchReq;
    logic [31:0] fetchAddr;
    logic        fetchGnt;
    logic        fetchValid;
    logic [31:0] fetchInstr;
    logic        fetchErr;
    logic        loadReq;
    logic        loadWe;
    logic [31:0] loadAddr;
    logic [31:0] loadData;
    logic        loadLock;
    logic        loadGnt;
    logic        loadValid;
    logic [31:0] loadRdata;
    logic        loadErr;
    logic        locked;
    logic        memEn;
    logic        memWe;
    logic [4:0]  memAddr;
    logic [31:0] memWdata;
    logic [31:0] memRdata;

    int tests;
    int fails;

    imem_arbiter #(.DEPTH(32), .STARVE_MAX(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fetchReq   (fetchReq),
        .fetchAddr  (fetchAddr),
        .fetchGnt   (fetchGnt),
        .fetchValid (fetchValid),
        .fetchInstr (fetchInstr),
        .fetchErr   (fetchErr),
        .loadReq    (loadReq),
        .loadWe     (loadWe),
        .loadAddr   (loadAddr),
        .loadData   (loadData),
        .loadLock   (loadLock),
        .loadGnt    (loadGnt),
        .loadValid  (loadValid),
        .loadRdata  (loadRdata),
        .loadErr    (loadErr),
        .locked     (locked),
        .memEn      (memEn),
        .memWe      (memWe),
        .memAddr    (memAddr),
        .memWdata   (memWdata),
        .memRdata   (memRdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: registered read, preload while mem_init is high.
    logic [31:0] mem [32];
    logic        mem_init;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'hA500_0000 + 32'(i);
        end else if (memEn) begin
            if (memWe) mem[memAddr] <= memWdata;
            else       memRdata     <= mem[memAddr];
        end
    end

    task automatic idle_inputs();
        fetchReq  = 1'b0;
        fetchAddr = 32'h0;
        loadReq   = 1'b0;
        loadWe    = 1'b0;
        loadAddr  = 32'h0;
        loadData  = 32'h0;
        loadLock  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        mem_init = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        tests++; if (fetchValid !== 1'b0) begin fails++; $display("FAIL reset_fetchValid got %0b want 0", fetchValid); end
        tests++; if (loadValid !== 1'b0) begin fails++; $display("FAIL reset_loadValid got %0b want 0", loadValid); end
        tests++; if (fetchInstr !== 32'h0) begin fails++; $display("FAIL reset_fetchInstr got %h want 0", fetchInstr); end
        tests++; if (loadRdata !== 32'h0) begin fails++; $display("FAIL reset_loadRdata got %h want 0", loadRdata); end
        tests++; if ({fetchErr, loadErr} !== 2'b00) begin fails++; $display("FAIL reset_err got %b want 00", {fetchErr, loadErr}); end
        tests++; if (locked !== 1'b0) begin fails++; $display("FAIL reset_locked got %0b want 0", locked); end
        tests++; if (memEn !== 1'b0) begin fails++; $display("FAIL reset_memEn got %0b want 0", memEn); end
        @(negedge clk);
        mem_init = 1'b0;
        rst_n    = 1'b1;
        $display("[TB] reset: outputs checked");
    endtask

    task automatic test_fetch_stream();
        logic [31:0] exp_instr [3];
        exp_instr[0] = 32'hA500_0000;
        exp_instr[1] = 32'hA500_0001;
        exp_instr[2] = 32'hA500_0002;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            fetchReq  = 1'b1;
            fetchAddr = 32'(4 * k);
            #1;
            tests++; if (fetchGnt !== 1'b1 || loadGnt !== 1'b0) begin fails++; $display("FAIL stream_gnt k=%0d got f=%0b l=%0b want f=1 l=0", k, fetchGnt, loadGnt); end
            tests++; if (memEn !== 1'b1 || memWe !== 1'b0 || memAddr !== 5'(k)) begin fails++; $display("FAIL stream_mem k=%0d got en=%0b we=%0b addr=%0d want 1 0 %0d", k, memEn, memWe, memAddr, k); end
            @(posedge clk);
            #1;
            tests++; if (fetchValid !== 1'b1 || fetchInstr !== exp_instr[k] || fetchErr !== 1'b0) begin fails++; $display("FAIL stream_resp k=%0d got v=%0b instr=%h err=%0b want 1 %h 0", k, fetchValid, fetchInstr, fetchErr, exp_instr[k]); end
            $display("[TB] fetch addr=%h instr=%h", fetchAddr, fetchInstr);
        end
        @(negedge clk);
        fetchReq = 1'b0;
        #1;
        tests++; if (fetchGnt !== 1'b0 || memEn !== 1'b0 || memAddr !== 5'd0) begin fails++; $display("FAIL stream_idle got gnt=%0b en=%0b addr=%0d want 0 0 0", fetchGnt, memEn, memAddr); end
        @(posedge clk);
        #1;
        tests++; if (fetchValid !== 1'b0 || fetchInstr !== 32'hA500_0002) begin fails++; $display("FAIL stream_hold got v=%0b instr=%h want 0 a5000002", fetchValid, fetchInstr); end
    endtask

    task automatic test_starvation();
        logic [1:0] exp_gnt;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            fetchReq  = 1'b1;
            fetchAddr = 32'hC;
            loadReq   = 1'b1;
            loadWe    = 1'b0;
            loadAddr  = 32'h10;
            #1;
            exp_gnt = (i % 5 == 4) ? 2'b10 : 2'b01;
            tests++; if ({fetchGnt, loadGnt} !== exp_gnt) begin fails++; $display("FAIL starve_gnt cycle=%0d got {f,l}=%b want %b", i, {fetchGnt, loadGnt}, exp_gnt); end
            @(posedge clk);
            #1;
            $display("[TB] starve cycle=%0d fValid=%0b lValid=%0b", i, fetchValid, loadValid);
            if (i == 3) begin
                tests++; if (loadValid !== 1'b1 || loadRdata !== 32'hA500_0004) begin fails++; $display("FAIL starve_load_resp got v=%0b data=%h want 1 a5000004", loadValid, loadRdata); end
            end
            if (i == 4) begin
                tests++; if (fetchValid !== 1'b1 || loadValid !== 1'b0 || fetchInstr !== 32'hA500_0003) begin fails++; $display("FAIL starve_fetch_resp got fv=%0b lv=%0b instr=%h want 1 0 a5000003", fetchValid, loadValid, fetchInstr); end
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_load_write();
        @(negedge clk);
        loadReq  = 1'b1;
        loadWe   = 1'b1;
        loadAddr = 32'h8;
        loadData = 32'hDEAD_BEEF;
        #1;
        tests++; if (loadGnt !== 1'b1 || memEn !== 1'b1 || memWe !== 1'b1 || memAddr !== 5'd2 || memWdata !== 32'hDEAD_BEEF) begin fails++; $display("FAIL write_mem got gnt=%0b en=%0b we=%0b addr=%0d wd=%h want 1 1 1 2 deadbeef", loadGnt, memEn, memWe, memAddr, memWdata); end
        @(posedge clk);
        #1;
        tests++; if (loadValid !== 1'b1 || loadRdata !== 32'h0 || loadErr !== 1'b0) begin fails++; $display("FAIL write_ack got v=%0b data=%h err=%0b want 1 0 0", loadValid, loadRdata, loadErr); end
        $display("[TB] load write addr=8 data=deadbeef ack=%0b", loadValid);
        @(negedge clk);
        idle_inputs();
        fetchReq  = 1'b1;
        fetchAddr = 32'h8;
        #1;
        tests++; if (fetchGnt !== 1'b1 || memWe !== 1'b0) begin fails++; $display("FAIL write_fetch_gnt got gnt=%0b we=%0b want 1 0", fetchGnt, memWe); end
        @(posedge clk);
        #1;
        tests++; if (fetchValid !== 1'b1 || fetchInstr !== 32'hDEAD_BEEF || loadValid !== 1'b0) begin fails++; $display("FAIL write_fetch_back got v=%0b instr=%h lv=%0b want 1 deadbeef 0", fetchValid, fetchInstr, loadValid); end
        $display("[TB] fetch addr=8 instr=%h", fetchInstr);
        @(negedge clk);
        idle_inputs();
        loadReq  = 1'b1;
        loadAddr = 32'h8;
        @(posedge clk);
        #1;
        tests++; if (loadValid !== 1'b1 || loadRdata !== 32'hDEAD_BEEF) begin fails++; $display("FAIL write_load_back got v=%0b data=%h want 1 deadbeef", loadValid, loadRdata); end
        $display("[TB] load read addr=8 data=%h", loadRdata);
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_bad_addr();
        logic [31:0] bad [2];
        bad[0] = 32'h6;
        bad[1] = 32'h80;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            fetchReq  = 1'b1;
            fetchAddr = bad[k];
            #1;
            tests++; if (fetchGnt !== 1'b1 || memEn !== 1'b0) begin fails++; $display("FAIL bad_fetch_mem addr=%h got gnt=%0b en=%0b want 1 0", bad[k], fetchGnt, memEn); end
            @(posedge clk);
            #1;
            tests++; if (fetchValid !== 1'b1 || fetchErr !== 1'b1 || fetchInstr !== 32'h0) begin fails++; $display("FAIL bad_fetch_resp addr=%h got v=%0b err=%0b instr=%h want 1 1 0", bad[k], fetchValid, fetchErr, fetchInstr); end
            $display("[TB] bad fetch addr=%h err=%0b", bad[k], fetchErr);
        end
        @(negedge clk);
        idle_inputs();
        loadReq  = 1'b1;
        loadAddr = 32'h81;
        #1;
        tests++; if (loadGnt !== 1'b1 || memEn !== 1'b0) begin fails++; $display("FAIL bad_load_mem got gnt=%0b en=%0b want 1 0", loadGnt, memEn); end
        @(posedge clk);
        #1;
        tests++; if (loadValid !== 1'b1 || loadErr !== 1'b1 || loadRdata !== 32'h0) begin fails++; $display("FAIL bad_load_resp got v=%0b err=%0b data=%h want 1 1 0", loadValid, loadErr, loadRdata); end
        $display("[TB] bad load addr=81 err=%0b", loadErr);
        // Last legal word: must reach memory and clear the error flag.
        @(negedge clk);
        idle_inputs();
        fetchReq  = 1'b1;
        fetchAddr = 32'h7C;
        #1;
        tests++; if (memEn !== 1'b1 || memAddr !== 5'd31) begin fails++; $display("FAIL edge_fetch_mem got en=%0b addr=%0d want 1 31", memEn, memAddr); end
        @(posedge clk);
        #1;
        tests++; if (fetchValid !== 1'b1 || fetchErr !== 1'b0 || fetchInstr !== 32'hA500_001F) begin fails++; $display("FAIL edge_fetch_resp got v=%0b err=%0b instr=%h want 1 0 a500001f", fetchValid, fetchErr, fetchInstr); end
        $display("[TB] fetch addr=7c instr=%h", fetchInstr);
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_lock();
        @(negedge clk);
        fetchReq  = 1'b1;
        fetchAddr = 32'h4;
        loadLock  = 1'b1;
        #1;
        tests++; if (fetchGnt !== 1'b1 || locked !== 1'b0) begin fails++; $display("FAIL lock_entry_gnt got gnt=%0b locked=%0b want 1 0", fetchGnt, locked); end
        @(posedge clk);
        #1;
        tests++; if (locked !== 1'b1 || fetchValid !== 1'b1 || fetchInstr !== 32'hA500_0001) begin fails++; $display("FAIL lock_inflight got locked=%0b v=%0b instr=%h want 1 1 a5000001", locked, fetchValid, fetchInstr); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            loadReq  = (i == 5);
            loadAddr = 32'h0;
            #1;
            tests++; if (fetchGnt !== 1'b0 || locked !== 1'b1) begin fails++; $display("FAIL lock_hold cycle=%0d got gnt=%0b locked=%0b want 0 1", i, fetchGnt, locked); end
            if (i == 5) begin
                tests++; if (loadGnt !== 1'b1) begin fails++; $display("FAIL lock_load_gnt got %0b want 1", loadGnt); end
            end
            $display("[TB] lock cycle=%0d fetchGnt=%0b loadGnt=%0b", i, fetchGnt, loadGnt);
        end
        @(negedge clk);
        loadLock = 1'b0;
        loadReq  = 1'b0;
        #1;
        tests++; if (fetchGnt !== 1'b0 || locked !== 1'b1) begin fails++; $display("FAIL unlock_same got gnt=%0b locked=%0b want 0 1", fetchGnt, locked); end
        @(negedge clk);
        #1;
        tests++; if (fetchGnt !== 1'b1 || locked !== 1'b0) begin fails++; $display("FAIL unlock_next got gnt=%0b locked=%0b want 1 0", fetchGnt, locked); end
        $display("[TB] unlock fetchGnt=%0b", fetchGnt);
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_reset_inflight();
        @(negedge clk);
        fetchReq  = 1'b1;
        fetchAddr = 32'h0;
        #1;
        tests++; if (fetchGnt !== 1'b1) begin fails++; $display("FAIL rst_pre_gnt got %0b want 1", fetchGnt); end
        @(posedge clk);
        #2;
        rst_n    = 1'b0;
        fetchReq = 1'b0;
        #1;
        tests++; if (fetchValid !== 1'b0 || fetchInstr !== 32'h0 || fetchErr !== 1'b0) begin fails++; $display("FAIL rst_fetch_out got v=%0b instr=%h err=%0b want 0 0 0", fetchValid, fetchInstr, fetchErr); end
        tests++; if (loadValid !== 1'b0 || loadRdata !== 32'h0 || loadErr !== 1'b0 || locked !== 1'b0) begin fails++; $display("FAIL rst_load_out got v=%0b data=%h err=%0b locked=%0b want 0 0 0 0", loadValid, loadRdata, loadErr, locked); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        tests++; if (fetchValid !== 1'b0) begin fails++; $display("FAIL rst_discard got v=%0b want 0", fetchValid); end
        @(negedge clk);
        fetchReq  = 1'b1;
        fetchAddr = 32'h4;
        #1;
        tests++; if (fetchGnt !== 1'b1 || locked !== 1'b0) begin fails++; $display("FAIL rst_run got gnt=%0b locked=%0b want 1 0", fetchGnt, locked); end
        $display("[TB] reset in flight: fetchValid=%0b fetchGnt=%0b", fetchValid, fetchGnt);
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        memRdata = 32'h0;
        test_reset();
        test_fetch_stream();
        test_starvation();
        test_load_write();
        test_bad_addr();
        test_lock();
        test_reset_inflight();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
